// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the CPU datapath and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wr_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wr_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit owning the MIPS HI/LO registers.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    mult_div_unit_if.slave bus
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // multiplicand or divisor magnitude
    logic [DW-1:0]    p_q, p_d;       // {acc, multiplier} or {rem, quo}
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [DW-1:0]    prod_fix;

    assign signed_op = ~bus.op[0];
    assign mag_a = (signed_op && bus.src_a[WIDTH-1]) ? (~bus.src_a) + WIDTH'(1) : bus.src_a;
    assign mag_b = (signed_op && bus.src_b[WIDTH-1]) ? (~bus.src_b) + WIDTH'(1) : bus.src_b;

    // One iteration of each algorithm; the FSM picks which result to keep.
    assign sum      = {1'b0, p_q[DW-1:WIDTH]} + {1'b0, a_q};
    assign rem_s    = p_q[DW-1:WIDTH-1];
    assign ge       = (rem_s >= {1'b0, a_q});
    assign diff     = rem_s[WIDTH-1:0] - a_q;
    assign prod_fix = neg_res_q ? (~p_q) + DW'(1) : p_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    cnt_d     = '0;
                    neg_res_d = signed_op & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                    neg_rem_d = signed_op & bus.op[1] & bus.src_a[WIDTH-1];
                    if (bus.op[1] && (bus.src_b == '0)) begin
                        // Divide by zero: preload the fixed result and skip CALC.
                        p_d       = {bus.src_a, {WIDTH{1'b1}}};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = FIX;
                    end else if (bus.op[1]) begin
                        a_d     = mag_b;
                        p_d     = {WIDTH'(0), mag_a};
                        state_d = CALC;
                    end else begin
                        a_d     = mag_a;
                        p_d     = {WIDTH'(0), mag_b};
                        state_d = CALC;
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wr_data;
                    if (bus.lo_we) lo_d = bus.wr_data;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    p_d = {(ge ? diff : rem_s[WIDTH-1:0]), p_q[WIDTH-2:0], ge};
                end else if (p_q[0]) begin
                    p_d = {sum, p_q[WIDTH-1:1]};
                end else begin
                    p_d = {1'b0, p_q[DW-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? (~p_q[WIDTH-1:0]) + WIDTH'(1) : p_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? (~p_q[DW-1:WIDTH]) + WIDTH'(1) : p_q[DW-1:WIDTH];
                end else begin
                    hi_d = prod_fix[DW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, ignored inputs, reset abort.
module tb_mult_div_unit;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one operation and measure edges-to-done and busy cycles (-1 on timeout).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 60) begin
            @(posedge clock); #1;
            lat++;
            if (bus.busy) bcnt++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
            bad++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, want all zero",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_multu();
        int lat, bcnt;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        total++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            bad++;
            $display("FAIL multu_result: got %h_%h want fffffffe_00000001", bus.hi, bus.lo);
        end
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL multu_latency: got %0d want 33", lat);
        end
        total++;
        if (bcnt !== 33) begin
            bad++;
            $display("FAIL multu_busy_cycles: got %0d want 33", bcnt);
        end
        @(posedge clock); #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL multu_done_pulse: done=%b one cycle later, want 0", bus.done);
        end
    endtask

    task automatic test_mult();
        int lat, bcnt;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
        total++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1 || lat !== 33) begin
            bad++;
            $display("FAIL mult_neg3x5: got %h_%h lat=%0d want ffffffff_fffffff1 lat=33",
                     bus.hi, bus.lo, lat);
        end
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        total++;
        if (bus.hi !== 32'h4000_0000 || bus.lo !== 32'h0) begin
            bad++;
            $display("FAIL mult_min_sq: got %h_%h want 40000000_00000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        int lat, bcnt;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        total++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF || lat !== 33) begin
            bad++;
            $display("FAIL div_neg7by2: got lo=%h hi=%h lat=%0d want lo=fffffffd hi=ffffffff lat=33",
                     bus.lo, bus.hi, lat);
        end
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        total++;
        if (bus.lo !== 32'h7FFF_FFFC || bus.hi !== 32'h1) begin
            bad++;
            $display("FAIL divu_big: got lo=%h hi=%h want lo=7ffffffc hi=00000001", bus.lo, bus.hi);
        end
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        total++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
            bad++;
            $display("FAIL div_overflow: got lo=%h hi=%h want lo=80000000 hi=00000000", bus.lo, bus.hi);
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        run_op(2'd3, 32'h1234_5678, 32'd0, lat, bcnt);
        total++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h1234_5678) begin
            bad++;
            $display("FAIL divzero_result: got lo=%h hi=%h want lo=ffffffff hi=12345678", bus.lo, bus.hi);
        end
        total++;
        if (lat !== 1 || bcnt !== 1) begin
            bad++;
            $display("FAIL divzero_timing: got lat=%0d busy=%0d want lat=1 busy=1", lat, bcnt);
        end
        @(posedge clock); #1;
    endtask

    // HI/LO hold 12345678/ffffffff from the divide-by-zero case on entry.
    task automatic test_ignored();
        int lat;
        logic stable;
        bus.op    = 2'd1;
        bus.src_a = 32'h0001_0000;
        bus.src_b = 32'h0001_0000;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat    = 0;
        stable = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            lat++;
        end
        bus.start   = 1'b1;
        bus.op      = 2'd3;
        bus.src_a   = 32'd5;
        bus.src_b   = 32'd0;
        bus.hi_we   = 1'b1;
        bus.lo_we   = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        lat++;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        while (!bus.done && lat < 60) begin
            if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'hFFFF_FFFF || bus.busy !== 1'b1)
                stable = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        total++;
        if (stable !== 1'b1) begin
            bad++;
            $display("FAIL ignored_during_calc: hi/lo changed or busy dropped, stable=%b want 1", stable);
        end
        total++;
        if (bus.hi !== 32'h1 || bus.lo !== 32'h0 || lat !== 33) begin
            bad++;
            $display("FAIL ignored_result: got %h_%h lat=%0d want 00000001_00000000 lat=33",
                     bus.hi, bus.lo, lat);
        end
        bus.hi_we   = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        bus.hi_we = 1'b0;
        total++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h0) begin
            bad++;
            $display("FAIL mthi_after_done: got hi=%h lo=%h want hi=deadbeef lo=00000000", bus.hi, bus.lo);
        end
        bus.lo_we   = 1'b1;
        bus.wr_data = 32'h0BAD_F00D;
        @(posedge clock); #1;
        bus.lo_we = 1'b0;
        total++;
        if (bus.lo !== 32'h0BAD_F00D || bus.hi !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL mtlo: got hi=%h lo=%h want hi=deadbeef lo=0badf00d", bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        bus.op    = 2'd1;
        bus.src_a = 32'hFFFF_FFFF;
        bus.src_b = 32'hFFFF_FFFF;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
            bad++;
            $display("FAIL reset_mid_async: hi=%h lo=%h busy=%b done=%b, want all zero",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_op(2'd1, 32'd3, 32'd4, lat, bcnt);
        total++;
        if (bus.lo !== 32'd12 || bus.hi !== 32'd0 || lat !== 33) begin
            bad++;
            $display("FAIL reset_mid_fresh: got lo=%h hi=%h lat=%0d want lo=0000000c hi=0 lat=33",
                     bus.lo, bus.hi, lat);
        end
    endtask

    // Second start issued on the edge right after done (34-cycle interval).
    task automatic test_back_to_back();
        int lat, bcnt;
        run_op(2'd3, 32'd100, 32'd7, lat, bcnt);
        total++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            bad++;
            $display("FAIL b2b_first: got lo=%h hi=%h want lo=0000000e hi=00000002", bus.lo, bus.hi);
        end
        run_op(2'd2, 32'd100, 32'hFFFF_FFF9, lat, bcnt);
        total++;
        if (bus.lo !== 32'hFFFF_FFF2 || bus.hi !== 32'd2 || lat !== 33) begin
            bad++;
            $display("FAIL b2b_second: got lo=%h hi=%h lat=%0d want lo=fffffff2 hi=00000002 lat=33",
                     bus.lo, bus.hi, lat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
